alu_seq: RTL and testbench

- Parametrised, registered, multi-cycle ALU for the 24-bit CPU datapath.
- Successor to the 1-bit ALU slice; keeps the same Op/BInvert encoding and adds NOR, logical right shift, a Start/Busy/Done handshake, and registered flags.
- Logic and arithmetic ops complete in one cycle; shifts run iteratively, one bit per cycle.
- Sits between the register-file read stage and writeback; the control unit sequences it through Start/Done.

---
 rtl/alu_seq.sv | 158 +++++++++++++++
 tb/tb_alu_seq.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered multi-cycle ALU for the 24-bit datapath.
//   Logic/arithmetic ops (Op 000-101) finish one edge after acceptance.
//   Shifts (Op 110 SLL, 111 SRL) step one bit per edge, k = min(B[SHAMT_W-1:0], WIDTH).
// Ports:
//   Clock, Reset (sync, active low)
//   Start, A, B, Op, BInvert   request, sampled only when accepted (Busy=0)
//   Result, CarryOut, Overflow, Zero   registered result and flags, held between Done pulses
//   Busy                        high while a shift is in progress
//   Done                        one-cycle pulse on the edge Result/flags load
module alu_seq #(
  parameter int WIDTH   = 24,
  parameter int SHAMT_W = 5
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Op,
  input  logic             BInvert,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             Overflow,
  output logic             Zero,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             cout;
    logic             ovf;
    logic             zero;
  } rsp_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt, step;
  logic [CW-1:0]    cnt, cnt_nxt, kc;
  logic             dir, dir_nxt;
  rsp_t             rsp_q, rsp_nxt, alu, pass;
  logic             done_q, done_nxt;
  logic [WIDTH-1:0] bp;
  logic [WIDTH:0]   sum;
  logic             add_ovf;
  logic             is_shift;

  // Shared adder: B' and carry-in both come from BInvert.
  assign bp       = BInvert ? ~B : B;
  assign sum      = {1'b0, A} + {1'b0, bp} + {{WIDTH{1'b0}}, BInvert};
  assign add_ovf  = (A[WIDTH-1] == bp[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
  assign is_shift = &Op[2:1];

  // Amounts of WIDTH or more clamp to WIDTH, which drains the register to 0.
  assign kc = (32'(B[SHAMT_W-1:0]) >= WIDTH) ? CW'(WIDTH) : CW'(B[SHAMT_W-1:0]);

  // dir=1 is SRL; zero fill both ways.
  assign step = dir ? {1'b0, sreg[WIDTH-1:1]} : {sreg[WIDTH-2:0], 1'b0};

  always_comb begin
    alu = '0;
    case (Op)
      3'b000: alu.res = A & bp;
      3'b001: alu.res = A | bp;
      3'b010: begin
        alu.res  = sum[WIDTH-1:0];
        alu.cout = sum[WIDTH];
        alu.ovf  = add_ovf;
      end
      3'b011: begin
        // Sign of the true difference; overflow output stays 0 for SLT.
        alu.res  = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
        alu.cout = sum[WIDTH];
      end
      3'b100:  alu.res = ~(A | bp);
      3'b101:  alu.res = A ^ bp;
      default: alu.res = '0;
    endcase
    alu.zero = (alu.res == '0);
  end

  // Zero-length shift result: A unchanged, no carry/overflow.
  always_comb begin
    pass      = '0;
    pass.res  = A;
    pass.zero = (A == '0);
  end

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    dir_nxt   = dir;
    rsp_nxt   = rsp_q;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (Start) begin
          if (!is_shift) begin
            rsp_nxt  = alu;
            done_nxt = 1'b1;
          end else if (kc == '0) begin
            rsp_nxt  = pass;
            done_nxt = 1'b1;
          end else begin
            sreg_nxt  = A;
            cnt_nxt   = kc;
            dir_nxt   = Op[0];
            state_nxt = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        // Start is ignored here: no queueing while busy.
        sreg_nxt = step;
        cnt_nxt  = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          rsp_nxt.res  = step;
          rsp_nxt.cout = 1'b0;
          rsp_nxt.ovf  = 1'b0;
          rsp_nxt.zero = (step == '0);
          done_nxt     = 1'b1;
          state_nxt    = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state  <= S_IDLE;
      sreg   <= '0;
      cnt    <= '0;
      dir    <= 1'b0;
      rsp_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      sreg   <= sreg_nxt;
      cnt    <= cnt_nxt;
      dir    <= dir_nxt;
      rsp_q  <= rsp_nxt;
      done_q <= done_nxt;
    end
  end

  assign Result   = rsp_q.res;
  assign CarryOut = rsp_q.cout;
  assign Overflow = rsp_q.ovf;
  assign Zero     = rsp_q.zero;
  assign Busy     = (state == S_SHIFT);
  assign Done     = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed checks for alu_seq (WIDTH=24, SHAMT_W=5).
//   Table of one-cycle ops applied back-to-back, then hand sequences for
//   shifts, ignored Start while busy, clamp, and reset in mid-shift.
module tb_alu_seq;
  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst_n, start, binv;
  logic [W-1:0] a, b, res;
  logic [2:0]   op;
  logic         cout, ovf, zero, busy, done;

  alu_seq #(.WIDTH(W), .SHAMT_W(5)) dut (
    .Clock(clk), .Reset(rst_n), .Start(start), .A(a), .B(b), .Op(op),
    .BInvert(binv), .Result(res), .CarryOut(cout), .Overflow(ovf),
    .Zero(zero), .Busy(busy), .Done(done)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    string        nm;
    logic [W-1:0] a, b;
    logic [2:0]   op;
    logic         binv;
    logic [W-1:0] r;
    logic         c, v, z;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(string nm, logic [W-1:0] a_, logic [W-1:0] b_, logic [2:0] op_,
                              logic bi, logic [W-1:0] r_, logic c_, logic v_, logic z_);
    vec_t t;
    t.nm = nm; t.a = a_; t.b = b_; t.op = op_; t.binv = bi;
    t.r = r_; t.c = c_; t.v = v_; t.z = z_;
    return t;
  endfunction

  // Runs one shift; lat = expected edges after acceptance until Done.
  // For lat>=2 an AND request is driven during the busy window and must be ignored.
  task automatic run_shift(input string nm, input logic [W-1:0] sa, input logic [W-1:0] sb,
                           input logic [2:0] sop, input logic [W-1:0] er, input int lat);
    logic [W-1:0] r0;
    int n, nb;
    bit hold_bad;
    start = 1'b1; a = sa; b = sb; op = sop; binv = 1'b0;
    @(posedge clk); #1;
    n = 0; nb = 0; hold_bad = 0; r0 = res;
    if (lat >= 2) begin
      a = '1; b = '1; op = 3'b000;
    end else begin
      start = 1'b0;
    end
    while (done !== 1'b1 && n < 60) begin
      if (busy === 1'b1) nb++;
      if (res !== r0) hold_bad = 1;
      @(posedge clk); #1;
      n++;
      start = 1'b0;
    end
    chk({nm, " latency"}, n, lat);
    chk({nm, " busy cycles"}, nb, lat);
    chk({nm, " result held while busy"}, {31'd0, hold_bad}, 0);
    chk({nm, " result"}, res, er);
    chk({nm, " zero"}, zero, (er == '0));
    chk({nm, " carry/ovf"}, {cout, ovf}, 2'b00);
    chk({nm, " busy after done"}, busy, 0);
    @(posedge clk); #1;
    chk({nm, " done single pulse"}, done, 0);
    chk({nm, " result hold"}, res, er);
  endtask

  initial begin
    tv.push_back(mk("add ovf",    24'h7FFFFF, 24'h000001, 3'b010, 0, 24'h800000, 0, 1, 0));
    tv.push_back(mk("sub eq",     24'h000005, 24'h000005, 3'b010, 1, 24'h000000, 1, 0, 1));
    tv.push_back(mk("slt -1<1",   24'hFFFFFF, 24'h000001, 3'b011, 1, 24'h000001, 1, 0, 0));
    tv.push_back(mk("nor",        24'hF0F0F0, 24'h0FF000, 3'b100, 0, 24'h000F0F, 0, 0, 0));
    tv.push_back(mk("xor inv",    24'hF0F0F0, 24'h0FF000, 3'b101, 1, 24'h00FF0F, 0, 0, 0));
    tv.push_back(mk("xor inv b0", 24'hF0F0F0, 24'h000000, 3'b101, 1, 24'h0F0F0F, 0, 0, 0));
    tv.push_back(mk("and inv",    24'hFFFFFF, 24'hFFFFFF, 3'b000, 1, 24'h000000, 0, 0, 1));
    tv.push_back(mk("and",        24'hF0F0F0, 24'hFFFFFF, 3'b000, 0, 24'hF0F0F0, 0, 0, 0));
    tv.push_back(mk("or zero",    24'h000000, 24'h000000, 3'b001, 0, 24'h000000, 0, 0, 1));
    tv.push_back(mk("or inv",     24'h000001, 24'hFFFFFF, 3'b001, 1, 24'h000001, 0, 0, 0));
    tv.push_back(mk("add carry",  24'hFFFFFF, 24'h000001, 3'b010, 0, 24'h000000, 1, 0, 1));
    tv.push_back(mk("sub ovf",    24'h800000, 24'h000001, 3'b010, 1, 24'h7FFFFF, 1, 1, 0));
    tv.push_back(mk("slt 3<7",    24'h000003, 24'h000007, 3'b011, 1, 24'h000001, 0, 0, 0));
    tv.push_back(mk("slt 7<3",    24'h000007, 24'h000003, 3'b011, 1, 24'h000000, 1, 0, 1));
    tv.push_back(mk("slt add ov", 24'h7FFFFF, 24'h000001, 3'b011, 0, 24'h000000, 0, 0, 1));
    tv.push_back(mk("sll k0",     24'h000001, 24'h000000, 3'b110, 0, 24'h000001, 0, 0, 0));
    tv.push_back(mk("srl k0 hi",  24'hABCDEF, 24'h000100, 3'b111, 0, 24'hABCDEF, 0, 0, 0));

    // Reset held two edges with Start asserted: nothing may complete.
    rst_n = 1'b0; start = 1'b1; a = 24'h7FFFFF; b = 24'h000001; op = 3'b010; binv = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("reset outputs", {res, cout, ovf, zero, busy, done}, 0);
    end
    rst_n = 1'b1;

    // Table: Start stays high, so each request is accepted in the previous Done cycle.
    foreach (tv[i]) begin
      start = 1'b1; a = tv[i].a; b = tv[i].b; op = tv[i].op; binv = tv[i].binv;
      @(posedge clk); #1;
      chk({tv[i].nm, " done"}, done, 1);
      chk({tv[i].nm, " busy"}, busy, 0);
      chk({tv[i].nm, " result"}, res, tv[i].r);
      chk({tv[i].nm, " flags c/v/z"}, {cout, ovf, zero}, {tv[i].c, tv[i].v, tv[i].z});
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("idle done low", done, 0);
    chk("idle result hold", res, 24'hABCDEF);

    run_shift("sll 5",      24'h000001, 24'h000005, 3'b110, 24'h000020, 5);
    run_shift("sll 23",     24'h000001, 24'h000017, 3'b110, 24'h800000, 23);
    run_shift("srl 1",      24'h000002, 24'h000001, 3'b111, 24'h000001, 1);
    run_shift("sll hi bits", 24'h000003, 24'h0000E2, 3'b110, 24'h00000C, 2);
    run_shift("sll 24",     24'hFFFFFF, 24'h000018, 3'b110, 24'h000000, 24);
    run_shift("srl 4",      24'hF0F0F0, 24'h000004, 3'b111, 24'h0F0F0F, 4);
    run_shift("srl clamp",  24'hFFFFFF, 24'h00001E, 3'b111, 24'h000000, 24);

    // Give Result a nonzero value, then reset in the middle of a clamped SRL.
    run_shift("sll pre", 24'h000001, 24'h000003, 3'b110, 24'h000008, 3);
    begin
      int nd;
      start = 1'b1; a = 24'hFFFFFF; b = 24'h00001E; op = 3'b111; binv = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 1; i < 10; i++) begin
        @(posedge clk); #1;
      end
      chk("pre-reset busy", busy, 1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("mid reset busy", busy, 0);
      chk("mid reset result", res, 0);
      chk("mid reset flags", {cout, ovf, zero, done}, 0);
      rst_n = 1'b1;
      nd = 0;
      for (int i = 0; i < 30; i++) begin
        if (done === 1'b1) nd++;
        @(posedge clk); #1;
      end
      chk("abandoned op done count", nd, 0);
    end
    run_shift("srl after reset", 24'hF0F0F0, 24'h000004, 3'b111, 24'h0F0F0F, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
